// File: rtl/bsg_vanilla_pkg.sv
// rtl/bsg_vanilla_pkg.sv - shared types and constants for the vanilla core network transmit path
package bsg_vanilla_pkg;

    // What the returned-response decoder decided to do with the incoming response
    typedef enum logic [1:0] {
        e_ret_none   = 2'd0,
        e_ret_ifetch = 2'd1,
        e_ret_wb     = 2'd2
    } return_kind_e;

    // Writeback channel indices; more channels may follow these
    localparam int wb_chan_int_gp   = 0;
    localparam int wb_chan_float_gp = 1;

    // clog2 that never returns zero, so a single channel still gets a 1-bit index
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/network_tx_wb_buffer.sv
// rtl/network_tx_wb_buffer.sv - small 1r1w FIFO used for writeback channels and the request queue
module network_tx_wb_buffer #(
    parameter int width_p = 37,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [cnt_w_lp-1:0] count;
    logic                do_enq;
    logic                do_deq;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign full_o  = (count == cnt_w_lp'(els_p));
    assign empty_o = (count == '0);
    assign data_o  = mem[rd_ptr];
    // A full buffer may accept a new entry only while its head is leaving
    assign do_deq  = deq_i & ~empty_o;
    assign do_enq  = enq_i & (~full_o | do_deq);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= bump(wr_ptr);
            if (do_deq) rd_ptr <= bump(rd_ptr);
            if (do_enq && !do_deq)      count <= count + cnt_w_lp'(1);
            else if (do_deq && !do_enq) count <= count - cnt_w_lp'(1);
        end
    end

    // Storage array; contents are don't-care while the buffer is empty
    always_ff @(posedge clk_i) begin
        if (do_enq) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/network_tx_credit_buffered.sv
// rtl/network_tx_credit_buffered.sv - credit-gated request issue with per-channel buffered writeback
module network_tx_credit_buffered
    import bsg_vanilla_pkg::*;
#(
    parameter int packet_width_p    = 128,
    parameter int data_width_p      = 32,
    parameter int reg_id_width_p    = 5,
    parameter int max_out_credits_p = 32,
    parameter int req_fifo_els_p    = 2,
    parameter int num_wb_channels_p = 2,
    parameter int wb_buffer_els_p   = 2,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
    localparam int chan_width_lp    = safe_clog2(num_wb_channels_p)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic                                        req_v_i,
    input  logic [packet_width_p-1:0]                   req_packet_i,
    input  logic                                        req_illegal_i,
    output logic                                        req_ready_o,
    output logic                                        invalid_access_o,
    output logic                                        out_v_o,
    output logic [packet_width_p-1:0]                   out_packet_o,
    input  logic                                        out_credit_i,
    input  logic                                        returned_v_i,
    input  logic                                        returned_is_ifetch_i,
    input  logic [chan_width_lp-1:0]                    returned_wb_chan_i,
    input  logic [data_width_p-1:0]                     returned_data_i,
    input  logic [reg_id_width_p-1:0]                   returned_reg_id_i,
    output logic                                        returned_yumi_o,
    output logic                                        ifetch_v_o,
    output logic [data_width_p-1:0]                     ifetch_instr_o,
    output logic [num_wb_channels_p-1:0]                wb_v_o,
    output logic [num_wb_channels_p*data_width_p-1:0]   wb_data_o,
    output logic [num_wb_channels_p*reg_id_width_p-1:0] wb_rd_o,
    output logic [num_wb_channels_p-1:0]                wb_force_o,
    input  logic [num_wb_channels_p-1:0]                wb_yumi_i,
    output logic [credit_width_lp-1:0]                  outstanding_o,
    output logic                                        drained_o
);

    localparam int                   wb_width_lp    = reg_id_width_p + data_width_p;
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    logic [credit_width_lp-1:0]   credits;
    logic                         req_full;
    logic                         req_empty;
    logic                         req_enq;
    logic                         send;
    logic                         chan_ok;
    return_kind_e                 ret_kind;
    logic [num_wb_channels_p-1:0] wb_enq;
    logic [num_wb_channels_p-1:0] wb_full;
    logic [num_wb_channels_p-1:0] wb_empty;

    assign req_ready_o      = ~req_full;
    assign invalid_access_o = req_v_i & req_ready_o & req_illegal_i;
    assign req_enq          = req_v_i & req_ready_o & ~req_illegal_i;
    // The network never backpressures, so any presented packet is sent
    assign out_v_o          = ~req_empty & (credits != '0);
    assign send             = out_v_o;
    assign outstanding_o    = max_credits_lp - credits;
    assign drained_o        = req_empty & (credits == max_credits_lp) & (&wb_empty);
    assign ifetch_instr_o   = returned_data_i;
    // Zero-extend both sides so the compare is exact even when the index field is full width
    assign chan_ok          = {1'b0, returned_wb_chan_i} < (chan_width_lp + 1)'(num_wb_channels_p);

    network_tx_wb_buffer #(
        .width_p(packet_width_p),
        .els_p  (req_fifo_els_p)
    ) u_req_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .enq_i    (req_enq),
        .data_i   (req_packet_i),
        .deq_i    (send),
        .data_o   (out_packet_o),
        .full_o   (req_full),
        .empty_o  (req_empty)
    );

    // Credit counter: send consumes one, a returned credit restores one, overflow saturates
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credits <= max_credits_lp;
        end else if (out_credit_i && !send) begin
            if (credits != max_credits_lp) credits <= credits + credit_width_lp'(1);
        end else if (send && !out_credit_i) begin
            credits <= credits - credit_width_lp'(1);
        end
    end

    // Response decode: ifetch passes straight through, writebacks enter their channel buffer
    always_comb begin
        ret_kind        = e_ret_none;
        wb_enq          = '0;
        returned_yumi_o = 1'b0;
        ifetch_v_o      = 1'b0;
        if (returned_v_i) begin
            if (returned_is_ifetch_i) ret_kind = e_ret_ifetch;
            else if (chan_ok)         ret_kind = e_ret_wb;
        end
        case (ret_kind)
            e_ret_ifetch: begin
                ifetch_v_o      = 1'b1;
                returned_yumi_o = 1'b1;
            end
            e_ret_wb: begin
                for (int c = 0; c < num_wb_channels_p; c++) begin
                    if (returned_wb_chan_i == chan_width_lp'(c) && (!wb_full[c] || wb_yumi_i[c])) begin
                        wb_enq[c]       = 1'b1;
                        returned_yumi_o = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    for (genvar c = 0; c < num_wb_channels_p; c++) begin : g_wb
        logic [wb_width_lp-1:0] head;

        network_tx_wb_buffer #(
            .width_p(wb_width_lp),
            .els_p  (wb_buffer_els_p)
        ) u_wb_buf (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .enq_i    (wb_enq[c]),
            .data_i   ({returned_reg_id_i, returned_data_i}),
            .deq_i    (wb_yumi_i[c]),
            .data_o   (head),
            .full_o   (wb_full[c]),
            .empty_o  (wb_empty[c])
        );

        assign wb_v_o[c]                                      = ~wb_empty[c];
        assign wb_force_o[c]                                  = wb_full[c];
        assign wb_data_o[c*data_width_p +: data_width_p]      = head[data_width_p-1:0];
        assign wb_rd_o[c*reg_id_width_p +: reg_id_width_p]    = head[wb_width_lp-1:data_width_p];
    end

    // Protocol checks on the network side: no credit beyond the reset pool, no bad channel index
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(out_credit_i && !send && credits == max_credits_lp));
            assert (!(returned_v_i && !returned_is_ifetch_i && !chan_ok));
        end
    end

endmodule

// File: doc/network_tx_credit_buffered.md
Name: network_tx_credit_buffered

Overview:
- Parametrised successor to the vanilla core's network transmit/response unit. Sits between the core's remote-request path and the manycore endpoint.
- Queues outgoing pre-built request packets and issues them under a credit counter.
- Demultiplexes returned responses into N independent writeback channels, each with its own elastic buffer, so a stalled core no longer forces same-cycle acceptance.
- Reports outstanding count and a drained status for fences.

Parameters:
- packet_width_p, 128, width of an outgoing request packet.
- data_width_p, 32, response data width.
- reg_id_width_p, 5, response destination register id width.
- max_out_credits_p, 32, network credits available at reset; must be ≥1.
- req_fifo_els_p, 2, outgoing request FIFO depth; must be ≥2.
- num_wb_channels_p, 2, writeback channels (0=int, 1=float, more allowed); must be ≥1.
- wb_buffer_els_p, 2, per-channel writeback buffer depth; must be ≥2.
- credit_width_lp (localparam), clog2(max_out_credits_p+1), width of the credit counter and outstanding_o.
- chan_width_lp (localparam), safe_clog2(num_wb_channels_p), width of returned_wb_chan_i.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- req_v_i  in  1  core request valid.
- req_packet_i  in  packet_width_p  fully formed request packet.
- req_illegal_i  in  1  request targets an invalid address; drop it.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- invalid_access_o  out  1  one-cycle pulse per dropped illegal request.
- out_v_o  out  1  packet valid to network (valid-credit interface).
- out_packet_o  out  packet_width_p  head of request FIFO.
- out_credit_i  in  1  one returned network credit.
- returned_v_i  in  1  response valid.
- returned_is_ifetch_i  in  1  response is an instruction fetch.
- returned_wb_chan_i  in  chan_width_lp  writeback channel index; used when not ifetch.
- returned_data_i  in  data_width_p  response data.
- returned_reg_id_i  in  reg_id_width_p  destination register.
- returned_yumi_o  out  1  response consumed this cycle.
- ifetch_v_o  out  1  instruction return valid; core must take it.
- ifetch_instr_o  out  data_width_p  instruction.
- wb_v_o  out  num_wb_channels_p  per-channel writeback valid.
- wb_data_o  out  num_wb_channels_p*data_width_p  per-channel data.
- wb_rd_o  out  num_wb_channels_p*reg_id_width_p  per-channel register id.
- wb_force_o  out  num_wb_channels_p  channel buffer full; core must yumi this cycle.
- wb_yumi_i  in  num_wb_channels_p  core consumes channel head.
- outstanding_o  out  credit_width_lp  equals max_out_credits_p minus current credits.
- drained_o  out  1  no queued, in-flight, or buffered traffic.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - Request FIFO and all wb buffers empty; credits = max_out_credits_p.
  - Outputs: out_v_o=0, req_ready_o=1 from the first cycle after reset, wb_v_o=0, wb_force_o=0, ifetch_v_o=0, returned_yumi_o=0, invalid_access_o=0, outstanding_o=0, drained_o=1.
  - Reset mid-operation discards all queued state and buffered responses; in-flight credits are lost by design.
- Request acceptance:
  - req_ready_o = request FIFO not full, combinational from FIFO state only.
  - On req_v_i & req_ready_o & req_illegal_i: packet is not enqueued; invalid_access_o=1 the same cycle.
  - When the FIFO is full, illegal requests stall like legal ones.
- Issue:
  - out_v_o = FIFO not empty & credits > 0. A send occurs on any cycle with out_v_o=1; the network has no backpressure.
  - A send dequeues the head and decrements credits. Enqueue and dequeue in the same cycle are legal, including when the FIFO is full only if dequeueing.
  - No bypass: enqueue-to-out_v_o latency is 1 cycle minimum.
- Credit counter:
  - +1 on out_credit_i, -1 on send; both in the same cycle leaves it unchanged.
  - out_credit_i at credits==max with no send is an error. Assert in simulation; the counter saturates.
- Responses:
  - Ifetch: ifetch_v_o = returned_v_i & returned_is_ifetch_i, with returned_yumi_o equal to it, same cycle.
  - Writeback: returned_yumi_o = returned_v_i & ~returned_is_ifetch_i & (target channel buffer not full, or full with wb_yumi_i of that channel asserted).
  - The writeback is enqueued into the target buffer; visible on wb_v_o the next cycle.
  - returned_wb_chan_i ≥ num_wb_channels_p is an error. Assert; the response is not consumed.
- Per-channel buffer:
  - wb_v_o[c] = buffer c not empty; wb_data_o and wb_rd_o show its head.
  - Head pops on wb_yumi_i[c].
  - wb_force_o[c] = buffer c full; the core must yumi that cycle (assert).
  - Channels are independent; FIFO order is kept within a channel.
- drained_o = request FIFO empty & credits==max_out_credits_p & all wb buffers empty. Combinational from registered state.

Decomposition:
- Return-response enum and channel index constants (int=0, float=1) go in bsg_vanilla_pkg.
- Sub-module network_tx_wb_buffer: a 1r1w small FIFO of {reg_id, data}, instantiated num_wb_channels_p times with a generate loop.
- The request FIFO reuses the same FIFO style at packet width.

Test Plan:
- Credit exhaustion: max_out_credits_p=4, enqueue 6 legal packets with no credits returned -> exactly 4 sends, outstanding_o=4, out_v_o=0. Then one out_credit_i -> 5th send next cycle, outstanding_o stays 4.
- Simultaneous events: credits=2, a send and out_credit_i in the same cycle -> credits remain 2. At the end, all credits returned and queues empty -> drained_o=1.
- Illegal drop: req_v_i=1, req_illegal_i=1, packet 0xDEAD -> invalid_access_o pulses one cycle, out_v_o never asserts, FIFO count unchanged.
- Ifetch pass-through: returned_v_i=1, returned_is_ifetch_i=1, data 0x00000013 -> ifetch_v_o=1, ifetch_instr_o=0x13, returned_yumi_o=1 all in the same cycle.
- Backpressure: wb_buffer_els_p=2, three int writebacks (rd=5,6,7) with wb_yumi_i=0 -> first two consumed, wb_force_o[0]=1, third held (returned_yumi_o=0). Meanwhile a float writeback (chan 1, rd=3) is consumed; wb_v_o=2'b11 in the next cycle.
- Reset mid-stream: reset_n_i=0 for 1 cycle with 2 queued packets and 1 buffered writeback -> the next cycle shows out_v_o=0, wb_v_o=0, outstanding_o=0, drained_o=1.
